tensor_ctrl_regs: RTL and testbench

Memory-mapped responder for the tensor controller window of the MMIO decoder. Accepts CPU-side register reads/writes on the `tc_*` request interface (offsets 0x0–0xC), holds the operation descriptor, launches the tensor engine, and tracks its progress. It also provides a watchdog abort and sticky completion/error status for the CPU to poll.

---
 rtl/tensor_ctrl_regs_pkg.sv | 10 +
 rtl/tensor_ctrl_regs_if.sv | 11 +
 rtl/tensor_ctrl_regs.sv | 80 ++++++++
 tb/tb_tensor_ctrl_regs.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tensor_ctrl_regs_pkg.sv
// tensor_pkg: register offsets, STATUS bit indices, opcodes and FSM states for tensor_ctrl_regs
package tensor_pkg;
  localparam logic [3:0] TC_CMD = 4'h0, TC_BASE = 4'h4, TC_LEN = 4'h8, TC_STATUS = 4'hC;
  localparam int ST_BUSY = 0, ST_DONE = 1, ST_BUSY_ERR = 2, ST_TIMEOUT = 3, ST_ADDR_ERR = 4;
  typedef enum logic [2:0] {
    OP_NOP, OP_COPY, OP_ADD, OP_MUL, OP_MAC, OP_RELU, OP_MAX, OP_CLR
  } te_op_t;
  typedef enum logic {B_IDLE, B_RESP} bus_state_t;
  typedef enum logic {E_IDLE, E_RUN} eng_state_t;
endpackage

// File: rtl/tensor_ctrl_regs_if.sv
// tensor_ctrl_regs_if: CPU-side tc_* register request/response bus
interface tensor_ctrl_regs_if;
  logic        tc_req;
  logic        tc_lw;
  logic [31:0] tc_addr;
  logic [31:0] tc_data_write;
  logic        tc_ack;
  logic [31:0] tc_read_data;
  modport master(output tc_req, tc_lw, tc_addr, tc_data_write, input tc_ack, tc_read_data);
  modport slave(input tc_req, tc_lw, tc_addr, tc_data_write, output tc_ack, tc_read_data);
endinterface

// File: rtl/tensor_ctrl_regs.sv
// tensor_ctrl_regs: MMIO register window that launches, watches and times out the tensor engine
module tensor_ctrl_regs
  import tensor_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  tensor_ctrl_regs_if.slave    tc,
  output logic                 te_start,
  output te_op_t               te_op,
  output logic [15:0]          te_base,
  output logic [15:0]          te_len,
  output logic                 te_abort,
  input  logic                 te_done
);
  bus_state_t  b_state, b_next;
  eng_state_t  e_state, e_next;
  logic [15:0] base, len, count;
  logic [4:1]  sticky, set, clr;
  logic [3:0]  off;
  logic [31:0] rdata, status;
  logic        acc, addr_ok, wr, busy, start_req, start_ok, start_rej, done_ev, expire;
  always_comb begin
    acc       = b_state == B_IDLE && tc.tc_req;
    b_next    = acc ? B_RESP : B_IDLE;
    addr_ok   = tc.tc_addr[31:4] == 28'd0 && tc.tc_addr[1:0] == 2'd0;
    off       = tc.tc_addr[3:0];
    wr        = acc && !tc.tc_lw && addr_ok;
    busy      = e_state == E_RUN;
    start_req = wr && off == TC_CMD && tc.tc_data_write[0];
    start_ok  = start_req && !busy;
    start_rej = start_req && busy;
    done_ev   = busy && te_done;
    // the watchdog fires on the cycle whose increment makes count equal TIMEOUT; done wins a tie
    expire    = busy && !te_done && count == 16'(TIMEOUT - 1);
    e_next    = start_ok ? E_RUN : (done_ev || expire) ? E_IDLE : e_state;
    set       = {acc && !addr_ok, expire, start_rej, done_ev};
    clr       = wr && off == TC_STATUS ? tc.tc_data_write[4:1] : 4'd0;
    status    = {count, 11'd0, sticky, busy};
    rdata     = off == TC_CMD  ? {28'd0, te_op, busy} :
                off == TC_BASE ? {16'd0, base} :
                off == TC_LEN  ? {16'd0, len} : status;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      b_state         <= B_IDLE;
      e_state         <= E_IDLE;
      tc.tc_ack       <= 1'b0;
      tc.tc_read_data <= 32'd0;
      base            <= 16'd0;
      len             <= 16'd0;
      count           <= 16'd0;
      sticky          <= 4'd0;
      te_start        <= 1'b0;
      te_abort        <= 1'b0;
      te_op           <= OP_NOP;
      te_base         <= 16'd0;
      te_len          <= 16'd0;
    end else begin
      b_state         <= b_next;
      e_state         <= e_next;
      tc.tc_ack       <= acc;
      tc.tc_read_data <= acc && tc.tc_lw && addr_ok ? rdata : 32'd0;
      if (wr && off == TC_BASE) base <= tc.tc_data_write[15:0];
      if (wr && off == TC_LEN) len <= tc.tc_data_write[15:0];
      sticky          <= (sticky & ~clr) | set;
      te_start        <= start_ok;
      te_abort        <= expire;
      if (start_ok) begin
        te_op   <= te_op_t'(tc.tc_data_write[3:1]);
        te_base <= base;
        te_len  <= len;
        count   <= 16'd0;
      end else if (busy) begin
        count <= count == 16'hFFFF ? count : count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_tensor_ctrl_regs.sv
// tb_tensor_ctrl_regs: random + directed check of two tensor_ctrl_regs instances against a behavioural model
module tb_tensor_ctrl_regs;
  import tensor_pkg::*;
  logic clk = 1'b0, rst = 1'b1, te_done = 1'b0;
  logic te_start_a, te_abort_a, te_start_b, te_abort_b;
  te_op_t te_op_a, te_op_b;
  logic [15:0] te_base_a, te_len_a, te_base_b, te_len_b;
  int total = 0, bad = 0;
  tensor_ctrl_regs_if ifa ();
  tensor_ctrl_regs_if ifb ();
  tensor_ctrl_regs #(.TIMEOUT(65535)) dut_a (
    .clk(clk), .rst(rst), .tc(ifa), .te_start(te_start_a), .te_op(te_op_a),
    .te_base(te_base_a), .te_len(te_len_a), .te_abort(te_abort_a), .te_done(te_done));
  tensor_ctrl_regs #(.TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .tc(ifb), .te_start(te_start_b), .te_op(te_op_b),
    .te_base(te_base_b), .te_len(te_len_b), .te_abort(te_abort_b), .te_done(te_done));
  always #5 clk = ~clk;
  int tmo[2] = '{65535, 8};
  int m_pend[2], m_busy[2], m_base[2], m_len[2], m_op[2], m_lbase[2], m_llen[2], m_cnt[2];
  int m_done[2], m_berr[2], m_to[2], m_aerr[2], x_ack[2], x_start[2], x_abort[2];
  logic [31:0] x_rd[2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_step(input int i, input logic r, input logic req, input logic lw,
                            input logic [31:0] a, input logic [31:0] d, input logic dn);
    int ob, acc, valid, wrv;
    x_ack[i] = 0; x_start[i] = 0; x_abort[i] = 0; x_rd[i] = 0;
    if (r) begin
      m_pend[i] = 0; m_busy[i] = 0; m_base[i] = 0; m_len[i] = 0; m_op[i] = 0; m_lbase[i] = 0;
      m_llen[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_berr[i] = 0; m_to[i] = 0; m_aerr[i] = 0;
      return;
    end
    ob = m_busy[i];
    acc = int'(req) & (m_pend[i] == 0 ? 1 : 0);
    m_pend[i] = acc;
    valid = (a[1:0] == 2'd0 && a < 32'd16) ? 1 : 0;
    wrv = acc & valid & int'(!lw);
    x_ack[i] = acc;
    if (acc && lw && valid)
      case (a[3:0])
        4'h0: x_rd[i] = 32'(m_op[i] * 2 + ob);
        4'h4: x_rd[i] = 32'(m_base[i]);
        4'h8: x_rd[i] = 32'(m_len[i]);
        default: x_rd[i] = 32'(m_cnt[i] * 65536 + m_aerr[i] * 16 + m_to[i] * 8 + m_berr[i] * 4 + m_done[i] * 2 + ob);
      endcase
    if (wrv && a == 32'hC) begin
      if (d[1]) m_done[i] = 0;
      if (d[2]) m_berr[i] = 0;
      if (d[3]) m_to[i] = 0;
      if (d[4]) m_aerr[i] = 0;
    end
    if (wrv && a == 32'h4) m_base[i] = int'(d[15:0]);
    if (wrv && a == 32'h8) m_len[i] = int'(d[15:0]);
    if (acc && !valid) m_aerr[i] = 1;
    if (ob) begin
      m_cnt[i] = m_cnt[i] < 65535 ? m_cnt[i] + 1 : 65535;
      if (dn) begin
        m_busy[i] = 0; m_done[i] = 1;
      end else if (m_cnt[i] == tmo[i]) begin
        m_busy[i] = 0; m_to[i] = 1; x_abort[i] = 1;
      end
    end
    if (wrv && a == 32'h0 && d[0]) begin
      if (ob) m_berr[i] = 1;
      else begin
        m_busy[i] = 1; m_op[i] = int'(d[3:1]); m_lbase[i] = m_base[i]; m_llen[i] = m_len[i];
        m_cnt[i] = 0; x_start[i] = 1;
      end
    end
  endtask
  task automatic compare();
    chk("a.ack", 32'(ifa.tc_ack), 32'(x_ack[0]));
    chk("a.rdata", ifa.tc_read_data, x_rd[0]);
    chk("a.start", 32'(te_start_a), 32'(x_start[0]));
    chk("a.abort", 32'(te_abort_a), 32'(x_abort[0]));
    chk("a.op", 32'(te_op_a), 32'(m_op[0]));
    chk("a.base", 32'(te_base_a), 32'(m_lbase[0]));
    chk("a.len", 32'(te_len_a), 32'(m_llen[0]));
    chk("b.ack", 32'(ifb.tc_ack), 32'(x_ack[1]));
    chk("b.rdata", ifb.tc_read_data, x_rd[1]);
    chk("b.start", 32'(te_start_b), 32'(x_start[1]));
    chk("b.abort", 32'(te_abort_b), 32'(x_abort[1]));
    chk("b.op", 32'(te_op_b), 32'(m_op[1]));
    chk("b.base", 32'(te_base_b), 32'(m_lbase[1]));
    chk("b.len", 32'(te_len_b), 32'(m_llen[1]));
  endtask
  task automatic tick(input logic r, input logic req, input logic lw, input logic [31:0] a,
                      input logic [31:0] d, input logic dn);
    rst = r; te_done = dn;
    ifa.tc_req = req; ifa.tc_lw = lw; ifa.tc_addr = a; ifa.tc_data_write = d;
    ifb.tc_req = req; ifb.tc_lw = lw; ifb.tc_addr = a; ifb.tc_data_write = d;
    model_step(0, r, req, lw, a, d, dn);
    model_step(1, r, req, lw, a, d, dn);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask
  task automatic bus(input logic lw, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] ra, output logic [31:0] rb);
    tick(0, 1, lw, a, d, 0);
    ra = ifa.tc_read_data; rb = ifb.tc_read_data;
    tick(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    logic [31:0] ra, rb, a, d;
    int k, acks;
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0, 0);
    chk("reset.ack", 32'(ifa.tc_ack), 0);
    chk("reset.len", 32'(te_len_a), 0);
    bus(0, 32'h4, 32'h0000_0123, ra, rb);
    bus(0, 32'h8, 32'hABCD_0040, ra, rb);
    bus(1, 32'h4, 0, ra, rb);
    chk("lit.base_rd", ra, 32'h0000_0123);
    bus(1, 32'h8, 0, ra, rb);
    chk("lit.len_rd", ra, 32'h0000_0040);
    tick(0, 1, 0, 32'h0, 32'h5, 0);
    chk("lit.start", 32'(te_start_a), 1);
    chk("lit.op", 32'(te_op_a), 2);
    chk("lit.tbase", 32'(te_base_a), 32'h123);
    chk("lit.tlen", 32'(te_len_a), 32'h40);
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    bus(1, 32'hC, 0, ra, rb);
    chk("lit.status_done", ra, 32'h000A_0002);
    bus(0, 32'h0, 32'h1, ra, rb);
    tick(0, 1, 0, 32'h0, 32'h3, 0);
    chk("lit.no_restart", 32'(te_start_a), 0);
    tick(0, 0, 0, 0, 0, 0);
    bus(1, 32'hC, 0, ra, rb);
    chk("lit.berr_busy", ra & 32'h7, 32'h7);
    bus(0, 32'hC, 32'h4, ra, rb);
    bus(1, 32'hC, 0, ra, rb);
    chk("lit.berr_clr", ra & 32'h7, 32'h3);
    tick(0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 32'h0, 32'h1, 0);
    chk("lit.b_start", 32'(te_start_b), 1);
    k = 1;
    while (k <= 20) begin
      tick(0, 0, 0, 0, 0, 0);
      if (te_abort_b) break;
      k++;
    end
    chk("lit.abort_delay", 32'(k), 8);
    bus(1, 32'hC, 0, ra, rb);
    chk("lit.status_to", rb, 32'h0008_0008);
    bus(1, 32'h10, 0, ra, rb);
    chk("lit.bad_rd", ra, 0);
    bus(0, 32'h6, 32'h0000_55AA, ra, rb);
    bus(1, 32'h4, 0, ra, rb);
    chk("lit.base_kept", ra, 0);
    bus(1, 32'hC, 0, ra, rb);
    chk("lit.aerr", (rb >> 4) & 32'h1, 1);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 1, 32'h8, 0, 0);
      acks += int'(ifa.tc_ack);
    end
    chk("lit.hold_acks", 32'(acks), 2);
    tick(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      case ($urandom % 6)
        0, 1: a = 32'h0;
        2: a = 32'h4;
        3: a = 32'h8;
        4: a = 32'hC;
        default: a = $urandom % 2 ? 32'h10 + 32'(4 * ($urandom % 4)) : 32'($urandom % 16) | 32'h1;
      endcase
      d = $urandom;
      tick(0, $urandom % 3 != 0, $urandom % 2 == 1, a, d, $urandom % 12 == 0);
    end
    tick(0, 0, 0, 0, 0, 0);
    bus(0, 32'h0, 32'hF, ra, rb);
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("lit.rst_start", 32'(te_start_a | te_start_b | te_abort_a | te_abort_b), 0);
    chk("lit.rst_op", 32'(te_op_a), 0);
    bus(1, 32'hC, 0, ra, rb);
    chk("lit.rst_status", ra | rb, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
